// File: rtl/tl45_pkg.sv
// Shared definitions for the TL45 load-use hazard controller slice.
package tl45_pkg;

   localparam int NREGS      = 16;
   localparam int REG_W      = $clog2(NREGS);
   localparam int PEND_W     = 2;
   localparam int STAT_W_DEF = 32;

   typedef logic [REG_W-1:0]  reg_idx_t;
   typedef logic [PEND_W-1:0] pend_cnt_t;

   // Largest number of long-latency writes one register may have in flight.
   localparam pend_cnt_t PEND_MAX = '1;

   // Opcode RR loads into its output buffer for a bubble (same as its flush NOP).
   localparam logic [4:0] OPC_NOP = 5'd0;

endpackage

// File: rtl/tl45_load_hazard_ctrl_if.sv
// Decode/EX/WB side signals of the load-use hazard controller.
// Handshake: decode holds i_issue_* stable while o_stall is high; an issue is
// taken on a rising edge where i_issue_valid=1, o_stall=0 and i_pipe_flush=0.
interface tl45_load_hazard_ctrl_if
   import tl45_pkg::*;
#(
   parameter int STAT_W = STAT_W_DEF
) ();

   logic              i_issue_valid;
   logic              i_issue_long;
   logic              i_issue_ri;
   reg_idx_t          i_issue_dr;
   reg_idx_t          i_issue_sr1;
   reg_idx_t          i_issue_sr2;
   logic              i_pipe_stall;
   logic              i_pipe_flush;
   logic              i_wb_valid;
   reg_idx_t          i_wb_reg;
   logic              o_stall;
   logic              o_bubble;
   logic [NREGS-1:0]  o_pending;
   logic [STAT_W-1:0] o_stall_count;

   modport master (
      output i_issue_valid, i_issue_long, i_issue_ri, i_issue_dr, i_issue_sr1, i_issue_sr2,
      output i_pipe_stall, i_pipe_flush, i_wb_valid, i_wb_reg,
      input  o_stall, o_bubble, o_pending, o_stall_count
   );

   modport slave (
      input  i_issue_valid, i_issue_long, i_issue_ri, i_issue_dr, i_issue_sr1, i_issue_sr2,
      input  i_pipe_stall, i_pipe_flush, i_wb_valid, i_wb_reg,
      output o_stall, o_bubble, o_pending, o_stall_count
   );

endinterface

// File: rtl/tl45_pend_counter.sv
// In-flight long-latency write counter for one architectural register.
// Simultaneous inc and dec cancel; dec on zero is ignored so stale
// writebacks cannot underflow. nonzero is registered from the next count.
module tl45_pend_counter
   import tl45_pkg::*;
(
   input  logic      i_clk,
   input  logic      i_reset_n,
   input  logic      inc,
   input  logic      dec,
   output pend_cnt_t cnt,
   output logic      nonzero
);

   pend_cnt_t cnt_nxt;

   // Net next count from this cycle's issue and writeback events.
   always_comb begin
      cnt_nxt = cnt;
      if (inc && !dec) begin
         cnt_nxt = cnt + PEND_W'(1);
      end else if (dec && !inc && (cnt != '0)) begin
         cnt_nxt = cnt - PEND_W'(1);
      end
   end

   // Count and its nonzero flag; reset drops every outstanding write.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         cnt     <= '0;
         nonzero <= 1'b0;
      end else begin
         cnt     <= cnt_nxt;
         nonzero <= (cnt_nxt != '0);
      end
   end

endmodule

// File: rtl/tl45_load_hazard_ctrl.sv
// Load-use hazard controller beside the RR stage: tracks in-flight loads per
// register and stalls/bubbles RR when a source depends on one of them, or
// when a new load would overflow its destination's counter.
module tl45_load_hazard_ctrl
   import tl45_pkg::*;
#(
   parameter int STAT_W = STAT_W_DEF
) (
   input  logic                   i_clk,
   input  logic                   i_reset_n,
   tl45_load_hazard_ctrl_if.slave bus
);

   logic [NREGS-1:0][PEND_W-1:0] cnt;
   logic [NREGS-1:0]             nonzero;
   logic [NREGS-1:0]             pend;
   logic                         raw;
   logic                         sat;
   logic                         hazard;
   logic                         stall;
   logic                         accept;
   logic                         wb_to_dr;
   logic [STAT_W-1:0]            stall_count_q;

   // r0 is hardwired zero and never has a write in flight.
   assign cnt[0]     = '0;
   assign nonzero[0] = 1'b0;

   // Pending view with same-cycle writeback bypass of the last outstanding write.
   always_comb begin
      pend = '0;
      for (int r = 1; r < NREGS; r++) begin
         pend[r] = (cnt[r] != '0) &&
                   !(bus.i_wb_valid && (bus.i_wb_reg == REG_W'(r)) && (cnt[r] == PEND_W'(1)));
      end
   end

   assign raw = bus.i_issue_valid &&
                (((bus.i_issue_sr1 != '0) && pend[bus.i_issue_sr1]) ||
                 (!bus.i_issue_ri && (bus.i_issue_sr2 != '0) && pend[bus.i_issue_sr2]));

   // A writeback to dr in the same cycle frees a slot, so a full counter is fine then.
   assign wb_to_dr = bus.i_wb_valid && (bus.i_wb_reg == bus.i_issue_dr);
   assign sat      = bus.i_issue_valid && bus.i_issue_long && (bus.i_issue_dr != '0) &&
                     (cnt[bus.i_issue_dr] == PEND_MAX) && !wb_to_dr;

   assign hazard = raw || sat;
   assign stall  = bus.i_pipe_stall || hazard;
   assign accept = bus.i_issue_valid && !stall && !bus.i_pipe_flush;

   assign bus.o_stall       = stall;
   assign bus.o_bubble      = hazard && !bus.i_pipe_stall && !bus.i_pipe_flush;
   assign bus.o_pending     = nonzero;
   assign bus.o_stall_count = stall_count_q;

   for (genvar r = 1; r < NREGS; r++) begin : g_reg
      logic inc_r;
      logic dec_r;

      assign inc_r = accept && bus.i_issue_long && (bus.i_issue_dr == REG_W'(r));
      assign dec_r = bus.i_wb_valid && (bus.i_wb_reg == REG_W'(r)) && (cnt[r] != '0);

      tl45_pend_counter u_cnt (
         .i_clk     (i_clk),
         .i_reset_n (i_reset_n),
         .inc       (inc_r),
         .dec       (dec_r),
         .cnt       (cnt[r]),
         .nonzero   (nonzero[r])
      );
   end

   // Hazard-stall cycle statistics; flushed cycles are not counted, wraps freely.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         stall_count_q <= '0;
      end else if (hazard && !bus.i_pipe_flush) begin
         stall_count_q <= stall_count_q + STAT_W'(1);
      end
   end

endmodule
